// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the result write-back stage.
//   - NSRC_DEFAULT : default number of result sources
//   - RA_W / NREG  : register-address width and register count
//   - src_e        : fixed source ordering (ALU has index 0, and so on)
//   - writes_reg() : true when a destination is a real register (not x0)
package regfile_writeback_pkg;

    localparam int NSRC_DEFAULT = 3;
    localparam int RA_W         = 5;
    localparam int NREG         = 32;

    typedef enum int {
        SRC_ALU    = 0,
        SRC_LSU    = 1,
        SRC_MULDIV = 2
    } src_e;

    // x0 is hard-wired to zero, so results targeting it are never written
    // and never tracked by the scoreboard.
    function automatic logic writes_reg(input logic [RA_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a single result source.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   push_valid/rd/data     : result offered by the source
//   grant                  : arbiter selected this slot this cycle
//   ready                  : slot can take a result this cycle
//   occ, rd, data          : current slot contents
module wb_slot
    import regfile_writeback_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    input  logic [RA_W-1:0] push_rd,
    input  logic [DW-1:0]   push_data,
    input  logic            grant,
    output logic            ready,
    output logic            occ,
    output logic [RA_W-1:0] rd,
    output logic [DW-1:0]   data
);

    logic            occ_reg;
    logic [RA_W-1:0] rd_reg;
    logic [DW-1:0]   data_reg;
    logic            take;

    // The granted entry leaves at the same edge, so it can be refilled
    // then: one result per cycle per source with no bubble.
    assign ready = !rst && (!occ_reg || grant);
    assign take  = push_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg  <= 1'b0;
            rd_reg   <= '0;
            data_reg <= '0;
        end else if (take && writes_reg(push_rd)) begin
            occ_reg  <= 1'b1;
            rd_reg   <= push_rd;
            data_reg <= push_data;
        end else if (grant) begin
            // Drained, and either not refilled or refilled with an x0
            // result that is dropped on the floor.
            occ_reg  <= 1'b0;
        end
    end

    assign occ  = occ_reg;
    assign rd   = rd_reg;
    assign data = data_reg;

endmodule

// File: rtl/regfile_writeback.sv
// Result write-back stage: buffers one result per source, picks one per
// cycle round-robin, drives the register-file write port and keeps a
// busy scoreboard of registers with an outstanding write.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   src_valid/src_rd/src_data     : per-source results (source i in slice i)
//   src_ready                     : per-source accept
//   iss_valid, iss_rd             : issued instruction that will write iss_rd
//   rf_we, rf_waddr, rf_wdata     : registered register-file write port
//   chk_addr1/2, chk_busy1/2      : hazard lookups (same-cycle write bypassed)
//   busy_vec                      : scoreboard state
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [RA_W*NSRC-1:0] src_rd,
    input  logic [DW*NSRC-1:0]   src_data,
    output logic [NSRC-1:0]      src_ready,
    input  logic                 iss_valid,
    input  logic [RA_W-1:0]      iss_rd,
    output logic                 rf_we,
    output logic [RA_W-1:0]      rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic [RA_W-1:0]      chk_addr1,
    input  logic [RA_W-1:0]      chk_addr2,
    output logic                 chk_busy1,
    output logic                 chk_busy2,
    output logic [NREG-1:0]      busy_vec
);

    localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] occ;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] above_last;
    logic [NSRC-1:0] req_hi;
    logic [NSRC-1:0] pick;
    logic [RA_W-1:0] slot_rd   [NSRC];
    logic [DW-1:0]   slot_data [NSRC];

    logic [GW-1:0]   last_grant_reg;
    logic [GW-1:0]   win_idx;
    logic [RA_W-1:0] sel_rd;
    logic [DW-1:0]   sel_data;

    logic            rf_we_reg;
    logic [RA_W-1:0] rf_waddr_reg;
    logic [DW-1:0]   rf_wdata_reg;
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // ---------------------------------------------------------------
    // Per-source slots
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
            wb_slot #(.DW(DW)) u_slot (
                .clk        (clk),
                .rst        (rst),
                .push_valid (src_valid[gi]),
                .push_rd    (src_rd[RA_W*gi +: RA_W]),
                .push_data  (src_data[DW*gi +: DW]),
                .grant      (grant[gi]),
                .ready      (src_ready[gi]),
                .occ        (occ[gi]),
                .rd         (slot_rd[gi]),
                .data       (slot_data[gi])
            );

            // Sources strictly after the last winner get first look.
            assign above_last[gi] = (GW'(gi) > last_grant_reg);
        end
    endgenerate

    // ---------------------------------------------------------------
    // Round-robin arbiter: lowest occupied slot above last_grant, else
    // wrap to the lowest occupied slot overall.
    // ---------------------------------------------------------------
    always_comb begin
        req_hi = occ & above_last;
        pick   = (|req_hi) ? req_hi : occ;
        // Isolate the lowest set bit of pick.
        grant  = rst ? '0 : (pick & (~pick + NSRC'(1)));

        win_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                win_idx  = win_idx | GW'(i);
                sel_rd   = sel_rd | slot_rd[i];
                sel_data = sel_data | slot_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GW'(NSRC - 1);
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
        end else if (|grant) begin
            last_grant_reg <= win_idx;
            rf_we_reg      <= 1'b1;
            rf_waddr_reg   <= sel_rd;
            rf_wdata_reg   <= sel_data;
        end else begin
            // Address and data hold so the port does not toggle when idle.
            rf_we_reg      <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Scoreboard: the write leaving the port clears its bit, a new issue
    // sets one; the issue is applied last so it wins on a collision.
    // ---------------------------------------------------------------
    always_comb begin
        busy_next = busy_reg;
        if (rf_we_reg) begin
            busy_next[rf_waddr_reg] = 1'b0;
        end
        if (iss_valid && writes_reg(iss_rd)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // The register file forwards the write on its port this cycle, so a
    // register being written right now is no longer a hazard.
    assign chk_busy1 = busy_reg[chk_addr1] && !(rf_we_reg && rf_waddr_reg == chk_addr1);
    assign chk_busy2 = busy_reg[chk_addr2] && !(rf_we_reg && rf_waddr_reg == chk_addr2);

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign busy_vec = busy_reg;

endmodule
